pipe_hazard_ctrl: RTL

Central sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MA/WB). It holds the pipeline idle while the testbench loads instruction memory, then runs it. In run mode it detects load-use hazards and inserts one bubble, squashes wrong-path instructions after a taken branch or jump resolved in EX, and drains and halts the pipeline on ECALL/EBREAK. It sits beside the forwarding unit and drives the PC enable and the IF/ID and ID/EX enable/flush controls.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-stage RV32I pipeline: load hold, load-use stall,
// taken-branch squash and ECALL/EBREAK drain. Optional perf counters: PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_done,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             halt_ID,
  input  logic [4:0]       rd_EX,
  input  logic             memread_EX,
  input  logic             pcsel_EX,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [1:0]       state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // load_done is a single-cycle pulse with no ready side: it is acted on only
  // when sampled high at a clock edge while in LOAD with reset_n high.
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          load_use;

  always_comb begin
    load_use = memread_EX && (rd_EX != 5'd0) &&
               ((use_rs1_ID && (rs1_ID == rd_EX)) || (use_rs2_ID && (rs2_ID == rd_EX)));
  end

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b1;
    idex_flush = 1'b1;
    halted     = 1'b0;
    case (state_q)
      S_LOAD: if (load_done) state_d = S_RUN;
      S_RUN: begin
        if (pcsel_EX) begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end else if (halt_ID) begin
          ifid_flush = 1'b0;
          state_d    = S_DRAIN;
          drain_d    = DRAIN_INIT;
        end else if (load_use) begin
          ifid_flush = 1'b0;
        end else begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b0;
          idex_flush = 1'b0;
        end
      end
      // Only bubbles reach EX here, so a stray pcsel_EX is deliberately ignored.
      S_DRAIN: begin
        ifid_flush = 1'b0;
        if (drain_q == '0) state_d = S_HALT;
        else               drain_d = drain_q - DW'(1);
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_LOAD;
    endcase
    if (!reset_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      halted     = 1'b0;
    end
    state = reset_n ? 2'(state_q) : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state_q == S_RUN) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (pcsel_EX)
        flush_cnt <= flush_cnt + CNT_W'(1);
      else if (!halt_ID && load_use)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
